// File: rtl/md_pkg.sv
// Shared encodings for the EXE-stage multiply/divide unit.
package md_pkg;

    localparam int unsigned MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // Operation context captured at accept and held until commit.
    typedef struct packed {
        md_op_e op;
        logic   sgn1;
        logic   sgn2;
        logic   signed_op;
        logic   div_zero;
    } md_ctl_t;

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_mul(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// Unsigned restoring divider: one quotient bit per cycle over XLEN cycles.
module md_div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r,
    output logic            valid_c
);

    localparam int unsigned CW = $clog2(XLEN);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            active_q;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            last;

    // Trial subtraction; MSB of diff set means the partial remainder was too small.
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        last   = active_q && (cnt_q == CW'(XLEN - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (kill) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            quo_q    <= dividend;
            rem_q    <= '0;
            dvs_q    <= divisor;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                active_q <= 1'b0;
            end
        end
    end

    assign q       = quo_q;
    assign r       = rem_q;
    assign valid_c = last;

endmodule

// File: rtl/es_muldiv_unit.sv
// EXE-stage multiply/divide unit owning the architectural HI/LO registers.
module es_muldiv_unit
    import md_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MUL_STAGES      = 2,
    parameter int unsigned DIV_ZERO_Q_ONES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MD_OP_W-1:0] in_op,
    input  logic [XLEN-1:0]    in_src1,
    input  logic [XLEN-1:0]    in_src2,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    hi,
    output logic [XLEN-1:0]    lo
);

    localparam int unsigned PW      = 2 * XLEN;
    localparam bit          DZ_ONES = (DIV_ZERO_Q_ONES != 0);

    md_state_e       state_q, state_d;
    md_ctl_t         ctl_q, ctl_d;
    logic [XLEN-1:0] src1_q, src2_q;
    logic [1:0]      mul_cnt_q, mul_cnt_d;
    logic [XLEN-1:0] hi_d, lo_d;
    logic            done_d;
    logic            busy_d;
    logic            capture;
    logic            div_start;

    md_op_e          op_in;
    logic            accept;
    logic            in_signed;
    logic            in_sgn1, in_sgn2;
    logic [XLEN-1:0] mag1, mag2;

    logic [PW-1:0]   a_ext, b_ext, prod;
    logic [PW-1:0]   mul_pipe [MUL_STAGES];
    logic [PW-1:0]   mul_res;

    logic [XLEN-1:0] div_q, div_r;
    logic            div_last_c;
    logic [XLEN-1:0] q_fix, r_fix;

    // Issue-side decode; magnitudes feed the divider directly at accept.
    always_comb begin
        op_in     = md_op_e'(in_op);
        accept    = in_valid && in_ready && !flush;
        in_signed = op_is_signed(op_in);
        in_sgn1   = in_signed && in_src1[XLEN-1];
        in_sgn2   = in_signed && in_src2[XLEN-1];
        mag1      = in_sgn1 ? (XLEN'(0) - in_src1) : in_src1;
        mag2      = in_sgn2 ? (XLEN'(0) - in_src2) : in_src2;
    end

    // Full-width product from extended operands, then delayed to MUL_STAGES.
    always_comb begin
        a_ext   = {{XLEN{ctl_q.signed_op & src1_q[XLEN-1]}}, src1_q};
        b_ext   = {{XLEN{ctl_q.signed_op & src2_q[XLEN-1]}}, src2_q};
        prod    = a_ext * b_ext;
        mul_res = mul_pipe[MUL_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                mul_pipe[i] <= '0;
            end
        end else if (state_q == ST_MUL) begin
            mul_pipe[0] <= prod;
            for (int unsigned i = 1; i < MUL_STAGES; i++) begin
                mul_pipe[i] <= mul_pipe[i-1];
            end
        end
    end

    md_div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .kill     (flush),
        .dividend (mag1),
        .divisor  (mag2),
        .q        (div_q),
        .r        (div_r),
        .valid_c  (div_last_c)
    );

    // Quotient sign follows the operand signs; remainder follows the dividend.
    always_comb begin
        q_fix = (ctl_q.sgn1 ^ ctl_q.sgn2) ? (XLEN'(0) - div_q) : div_q;
        r_fix = ctl_q.sgn1 ? (XLEN'(0) - div_r) : div_r;
    end

    always_comb begin
        state_d   = state_q;
        ctl_d     = ctl_q;
        mul_cnt_d = mul_cnt_q;
        hi_d      = hi;
        lo_d      = lo;
        done_d    = 1'b0;
        capture   = 1'b0;
        div_start = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    capture         = 1'b1;
                    mul_cnt_d       = '0;
                    ctl_d.op        = op_in;
                    ctl_d.sgn1      = in_sgn1;
                    ctl_d.sgn2      = in_sgn2;
                    ctl_d.signed_op = in_signed;
                    ctl_d.div_zero  = (in_src2 == '0);
                    case (op_in)
                        MD_MTHI: begin
                            hi_d   = in_src1;
                            done_d = 1'b1;
                        end
                        MD_MTLO: begin
                            lo_d   = in_src1;
                            done_d = 1'b1;
                        end
                        MD_MULT, MD_MULTU: state_d = ST_MUL;
                        MD_DIV, MD_DIVU: begin
                            if (in_src2 == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d   = ST_DIV;
                                div_start = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                mul_cnt_d = mul_cnt_q + 2'd1;
                if (mul_cnt_q == 2'(MUL_STAGES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                if (div_last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (op_is_mul(ctl_q.op)) begin
                    {hi_d, lo_d} = mul_res;
                    done_d       = 1'b1;
                end else if (ctl_q.div_zero) begin
                    if (DZ_ONES) begin
                        lo_d   = '1;
                        hi_d   = src1_q;
                        done_d = 1'b1;
                    end
                end else begin
                    lo_d   = q_fix;
                    hi_d   = r_fix;
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Cancellation overrides everything, including a pending commit.
        if (flush) begin
            state_d   = ST_IDLE;
            hi_d      = hi;
            lo_d      = lo;
            done_d    = 1'b0;
            div_start = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ctl_q     <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            mul_cnt_q <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            ctl_q     <= ctl_d;
            mul_cnt_q <= mul_cnt_d;
            if (capture) begin
                src1_q <= in_src1;
                src2_q <= in_src2;
            end
            hi        <= hi_d;
            lo        <= lo_d;
            done      <= done_d;
            busy      <= busy_d;
            in_ready  <= !busy_d;
        end
    end

endmodule

// File: tb/tb_es_muldiv_unit.sv
// Scoreboard bench for es_muldiv_unit: arithmetic reference model, flush/reset cases, 16-bit instance.
module tb_es_muldiv_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, in_ready, flush, busy, done;
    logic [2:0]  in_op;
    logic [31:0] in_src1, in_src2, hi, lo;

    logic        s_reset, s_in_valid, s_in_ready, s_flush, s_busy, s_done;
    logic [2:0]  s_in_op;
    logic [15:0] s_in_src1, s_in_src2, s_hi, s_lo;

    es_muldiv_unit #(.XLEN(32), .MUL_STAGES(2), .DIV_ZERO_Q_ONES(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    es_muldiv_unit #(.XLEN(16), .MUL_STAGES(1), .DIV_ZERO_Q_ONES(1)) dut16 (
        .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_op(s_in_op), .in_src1(s_in_src1), .in_src2(s_in_src2), .flush(s_flush),
        .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic [15:0] m16_hi = '0;
    logic [15:0] m16_lo = '0;

    // Reference: plain integer arithmetic on w-bit values held in longints.
    function automatic void ref_model(input int w, input int ms, input logic [2:0] op,
                                      input longint a, input longint b,
                                      input longint old_hi, input longint old_lo,
                                      output longint nhi, output longint nlo,
                                      output int lat, output bit commit);
        longint mask, sa, sbv, p, q, r;
        bit     sgn;
        mask   = (longint'(1) << w) - 1;
        sgn    = (op == 3'd0) || (op == 3'd2);
        sa     = a;
        sbv    = b;
        if (sgn && a[w-1]) sa = a - (longint'(1) << w);
        if (sgn && b[w-1]) sbv = b - (longint'(1) << w);
        nhi    = old_hi;
        nlo    = old_lo;
        lat    = 0;
        commit = 1'b1;
        case (op)
            3'd0, 3'd1: begin
                p   = sgn ? sa * sbv : a * b;
                nlo = p & mask;
                nhi = (p >> w) & mask;
                lat = ms + 1;
            end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    nlo = mask;
                    nhi = a;
                    lat = 1;
                end else begin
                    q   = sgn ? sa / sbv : a / b;
                    r   = sgn ? sa % sbv : a % b;
                    nlo = q & mask;
                    nhi = r & mask;
                    lat = w + 1;
                end
            end
            3'd4: nhi = a;
            3'd5: nlo = a;
            default: commit = 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (done === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: cycle %0d got done=1 (hi=%h lo=%h) want no pulse", cyc, hi, lo);
            end else begin
                mon_e = exp_q.pop_front();
                if (hi !== mon_e.hi || lo !== mon_e.lo || cyc != mon_e.cyc) begin
                    n_err++;
                    $display("FAIL %s: got hi=%h lo=%h at cycle %0d, want hi=%h lo=%h at cycle %0d",
                             mon_e.name, hi, lo, cyc, mon_e.hi, mon_e.lo, mon_e.cyc);
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int k = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (in_ready !== 1'b1) chk({name, "_ready_timeout"}, 64'(in_ready), 64'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name);
        longint nh, nl;
        int     lat;
        bit     cm;
        exp_t   e;
        wait_ready(name);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        ref_model(32, 2, op, longint'({32'd0, a}), longint'({32'd0, b}),
                  longint'({32'd0, m_hi}), longint'({32'd0, m_lo}), nh, nl, lat, cm);
        if (cm) begin
            m_hi   = nh[31:0];
            m_lo   = nl[31:0];
            e.hi   = m_hi;
            e.lo   = m_lo;
            e.cyc  = cyc + 1 + lat;
            e.name = name;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (cm) chk({name, "_busy"}, 64'(busy), 64'(lat > 0));
    endtask

    // Accept an operation that is expected to be cancelled; returns the accept edge.
    task automatic start_raw(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int acc);
        wait_ready("raw");
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        @(negedge clk);
        in_valid = 1'b0;
        acc      = cyc;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || in_ready !== 1'b1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input string name);
        longint nh, nl;
        int     lat, k;
        bit     cm;
        ref_model(16, 1, op, longint'({48'd0, a}), longint'({48'd0, b}),
                  longint'({48'd0, m16_hi}), longint'({48'd0, m16_lo}), nh, nl, lat, cm);
        m16_hi = nh[15:0];
        m16_lo = nl[15:0];
        @(negedge clk);
        chk({name, "_ready"}, 64'(s_in_ready), 64'd1);
        s_in_valid = 1'b1;
        s_in_op    = op;
        s_in_src1  = a;
        s_in_src2  = b;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        k = 0;
        while (k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (s_done === 1'b1) break;
        end
        chk({name, "_latency"}, 64'(k), 64'(lat));
        chk({name, "_hi"}, 64'(s_hi), 64'(m16_hi));
        chk({name, "_lo"}, 64'(s_lo), 64'(m16_lo));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    initial begin
        int          acc;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel;

        reset = 1'b1;  in_valid = 1'b0;  in_op = '0;  in_src1 = '0;  in_src2 = '0;  flush = 1'b0;
        s_reset = 1'b1; s_in_valid = 1'b0; s_in_op = '0; s_in_src1 = '0; s_in_src2 = '0; s_flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        reset   = 1'b0;
        s_reset = 1'b0;

        issue(MD_MULT,  32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
        issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3, "multu_fffffffex3");
        issue(MD_DIV,   32'hFFFF_FFF9, 32'd2, "div_m7_2");
        issue(MD_DIVU,  32'd100, 32'd7, "divu_100_7");
        issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_intmin_m1");
        issue(MD_DIVU,  32'd5, 32'd0, "divu_by_zero");
        issue(MD_DIV,   32'hFFFF_FF00, 32'd0, "div_neg_by_zero");
        issue(MD_MTLO,  32'hCAFE_F00D, 32'd0, "mtlo");
        issue(MD_MTHI,  32'h0BAD_BEEF, 32'd0, "mthi");
        drain("directed");
        chk("directed_hi_const", 64'(hi), 64'h0BAD_BEEF);

        // Flush ten cycles into a divide.
        start_raw(MD_DIV, 32'd40, 32'd3, acc);
        while (cyc < acc + 9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_mid_in_ready", 64'(in_ready), 64'd1);
        chk("flush_mid_busy", 64'(busy), 64'd0);
        chk("flush_mid_hi", 64'(hi), 64'(m_hi));
        chk("flush_mid_lo", 64'(lo), 64'(m_lo));
        issue(MD_MTHI, 32'h0000_1234, 32'd0, "mthi_after_flush");
        drain("after_flush");
        chk("mthi_after_flush_const", 64'(hi), 64'h1234);

        // Flush landing exactly on the commit cycle.
        start_raw(MD_DIV, 32'd1000, 32'd9, acc);
        while (cyc < acc + 32) @(negedge clk);
        chk("flush_done_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done_busy_after", 64'(busy), 64'd0);
        chk("flush_done_hi", 64'(hi), 64'(m_hi));
        chk("flush_done_lo", 64'(lo), 64'(m_lo));

        // Flush in the accept cycle blocks the accept.
        @(negedge clk);
        in_valid = 1'b1; in_op = MD_MULT; in_src1 = 32'd9; in_src2 = 32'd9; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("flush_accept_hi", 64'(hi), 64'(m_hi));
        chk("flush_accept_lo", 64'(lo), 64'(m_lo));

        // Reset in the middle of a divide.
        issue(MD_MTLO, 32'h0000_A5A5, 32'd0, "mtlo_before_reset");
        drain("before_reset");
        start_raw(MD_DIV, 32'd77, 32'd5, acc);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        chk("reset_mid_hi", 64'(hi), 64'd0);
        chk("reset_mid_lo", 64'(lo), 64'd0);
        chk("reset_mid_busy", 64'(busy), 64'd0);
        chk("reset_mid_in_ready", 64'(in_ready), 64'd1);

        // Randomised mix with corner operands.
        for (int i = 0; i < 80; i++) begin
            op  = 3'($urandom_range(0, 5));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 255));
                4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            issue(op, a, b, $sformatf("rand%0d_op%0d", i, op));
        end
        drain("random");

        // Narrow instance: widths and latencies scale.
        chk("w16_reset_hi", 64'(s_hi), 64'd0);
        run16(MD_MULT,  16'hFFFE, 16'd3, "w16_mult");
        run16(MD_MULTU, 16'hFFFE, 16'd3, "w16_multu");
        run16(MD_DIV,   16'hFFF9, 16'd2, "w16_div");
        run16(MD_DIVU,  16'd100, 16'd7, "w16_divu");
        run16(MD_DIV,   16'h8000, 16'hFFFF, "w16_intmin");
        run16(MD_DIVU,  16'd5, 16'd0, "w16_divzero");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
